// File: rtl/apb3_master_arb.sv
// Round-robin arbiter that shares one APB3 master port between NUM_REQ requesters.
// Sequences SETUP/ACCESS, bounds the PREADY wait, and returns data/error per requester.
module apb3_master_arb #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [DATA_WIDTH-1:0]         pwdata,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pready,
  input  logic                          pslverr
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        gnt_q, gnt_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    busy_q, busy_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;

  logic                    gnt_found;
  logic [PTR_W-1:0]        gnt_idx;
  logic [PTR_W-1:0]        cand;
  logic                    timeout_hit;

  // First pending requester scanning upward from the rotating pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Accept pulse is combinational; gated by rst_n so it drops the instant reset asserts.
  assign req_ready = (rst_n && state_q == IDLE && gnt_found) ? (NUM_REQ'(1) << gnt_idx) : '0;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    busy_d      = busy_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          state_d  = SETUP;
          gnt_d    = gnt_idx;
          ptr_d    = PTR_W'((32'(gnt_idx) + 1) % NUM_REQ);
          paddr_d  = req_addr[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          pwdata_d = req_wdata[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
          pwrite_d = req_write[gnt_idx];
          psel_d   = 1'b1;
          busy_d   = 1'b1;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (pready || timeout_hit) begin
          state_d             = IDLE;
          psel_d              = 1'b0;
          penable_d           = 1'b0;
          busy_d              = 1'b0;
          rsp_valid_d[gnt_q]  = 1'b1;
          // A late PREADY in the abort cycle still completes the transfer normally.
          rsp_err_d           = pready ? pslverr : 1'b1;
          rsp_rdata_d         = (pready && !pwrite_q) ? prdata : '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb3_master_arb.sv
// Bench for apb3_master_arb: vector table plus hand sequences, with a response scoreboard
// and a small APB slave model with configurable wait states, error and never-ready modes.
module tb_apb3_master_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [23:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata, pwdata, prdata;
  logic        rsp_err, busy, psel, penable, pwrite, pready, pslverr;
  logic [11:0] paddr;

  apb3_master_arb #(.NUM_REQ(2), .ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Slave model
  logic [31:0] s_rdata = 32'h0;
  int          s_waits = 0;
  logic        s_err = 1'b0;
  logic        s_never = 1'b0;
  int          acc_cnt;
  assign pready  = psel && penable && !s_never && (acc_cnt == s_waits);
  assign pslverr = pready && s_err;
  assign prdata  = s_rdata;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  // Scoreboard
  typedef struct {
    logic [1:0]  onehot;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t sb[$];

  logic [11:0] cur_addr;
  logic        cur_write;
  logic [31:0] cur_wdata;
  int          model_ptr = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (penable && !psel) begin
        checks++; failures++;
        $display("FAIL apb_penable_without_psel actual=1 required=0");
      end
      if (psel && penable) begin
        chk("apb_paddr", 32'(paddr), 32'(cur_addr));
        chk("apb_pwrite", 32'(pwrite), 32'(cur_write));
        chk("apb_pwdata", pwdata, cur_wdata);
      end
      if (rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp actual=%b required=00", rsp_valid);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(e.onehot));
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  // Drive one request on requester idx; returns at the negedge after acceptance.
  task automatic do_req(input int idx, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    bit got = 0;
    req_write[idx] = wr;
    req_addr[idx*12 +: 12] = a;
    req_wdata[idx*32 +: 32] = wd;
    req_valid[idx] = 1'b1;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (req_ready != 2'b00) begin got = 1; break; end
      @(negedge clk);
    end
    chk("accept_onehot", 32'(req_ready), 32'(2'b01 << idx));
    if (got) begin
      rsp_t e;
      cur_addr = a; cur_write = wr; cur_wdata = wd;
      e.onehot = 2'(2'b01 << idx); e.rdata = exp_rd; e.err = exp_err;
      sb.push_back(e);
      model_ptr = (idx + 1) % 2;
    end
    @(negedge clk);
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0 && !busy) begin done = 1; break; end
      @(negedge clk);
    end
    chk("completion_within_bound", 32'(done), 32'd1);
  endtask

  typedef struct {
    int          idx;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic [31:0] prd;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int pen_cnt;
    bit seen;
    vecs[0] = '{1, 1'b1, 12'hFFC, 32'h12345678, 3, 1'b1, 32'hAAAA5555, 32'h0,        1'b1};
    vecs[1] = '{0, 1'b0, 12'h004, 32'h11111111, 0, 1'b0, 32'h0BADF00D, 32'h0BADF00D, 1'b0};
    vecs[2] = '{1, 1'b0, 12'h800, 32'h22222222, 2, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1};
    vecs[3] = '{0, 1'b1, 12'h000, 32'hFFFFFFFF, 1, 1'b0, 32'h33333333, 32'h0,        1'b0};
    vecs[4] = '{1, 1'b1, 12'h7FF, 32'h0F0F0F0F, 0, 1'b0, 32'h44444444, 32'h0,        1'b0};

    rst_n = 1'b0; req_valid = 2'b11; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_psel_penable", 32'({psel, penable}), 32'd0);
    chk("reset_busy_rsp", 32'({busy, rsp_valid, rsp_err}), 32'd0);
    chk("reset_paddr_pwdata", 32'(paddr) | pwdata | rsp_rdata, 32'd0);
    req_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Single zero-wait read: latency T, T+1, T+2, T+3
    s_waits = 0; s_rdata = 32'hDEADBEEF; s_err = 1'b0;
    do_req(0, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0);
    chk("t1_setup_psel_penable", 32'({psel, penable}), 32'(2'b10));
    chk("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_access_psel_penable", 32'({psel, penable}), 32'(2'b11));
    @(negedge clk);
    chk("t1_rsp_at_t3", 32'(rsp_valid), 32'(2'b01));
    chk("t1_idle_psel", 32'({psel, penable, busy}), 32'd0);
    repeat (2) @(negedge clk);
    chk("t1_rdata_hold", rsp_rdata, 32'hDEADBEEF);

    // Table-driven single transfers
    for (int v = 0; v < 5; v++) begin
      s_waits = vecs[v].waits; s_err = vecs[v].err; s_rdata = vecs[v].prd;
      do_req(vecs[v].idx, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata, vecs[v].exp_err);
      wait_done();
    end

    // Both requesters held: grants must alternate starting from the pointer
    s_waits = 1; s_err = 1'b0; s_rdata = 32'h5A5A0001;
    req_write = 2'b10; req_addr = {12'h200, 12'h100}; req_wdata = {32'hA1A1A1A1, 32'hB2B2B2B2};
    chk("t3_ptr_start", 32'(model_ptr), 32'd0);
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      bit got = 0;
      int g;
      for (int k = 0; k < 64; k++) begin
        #1;
        if (req_ready != 2'b00) begin got = 1; break; end
        @(negedge clk);
      end
      g = model_ptr;
      chk("t3_grant_order", 32'(req_ready), 32'(2'b01 << g));
      if (got) begin
        rsp_t e;
        cur_addr = req_addr[g*12 +: 12]; cur_write = req_write[g]; cur_wdata = req_wdata[g*32 +: 32];
        e.onehot = 2'(2'b01 << g); e.rdata = req_write[g] ? 32'h0 : s_rdata; e.err = 1'b0;
        sb.push_back(e);
        model_ptr = (g + 1) % 2;
      end
      @(negedge clk);
      if (n == 3) req_valid = 2'b00;
    end
    wait_done();

    // Timeout: never ready, penable exactly 8 cycles
    s_never = 1'b1; s_rdata = 32'hFEEDFACE;
    do_req(0, 1'b0, 12'h123, 32'h0, 32'h0, 1'b1);
    pen_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (penable) pen_cnt++;
      if (rsp_valid != 2'b00) break;
      @(negedge clk);
    end
    chk("t4_penable_cycles", 32'(pen_cnt), 32'd8);
    s_never = 1'b0;
    wait_done();

    // Reset during ACCESS drops the transfer
    s_waits = 5; s_rdata = 32'h0000AAAA;
    do_req(1, 1'b0, 12'h0AA, 32'h0, 32'h0000AAAA, 1'b0);
    for (int k = 0; k < 10 && !penable; k++) @(negedge clk);
    req_valid[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_psel_penable", 32'({psel, penable}), 32'd0);
    chk("t5_rst_ready_rsp", 32'({req_ready, rsp_valid}), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_idle_after_release", 32'(busy), 32'd0);
    s_waits = 0; s_rdata = 32'h0000BBBB;
    do_req(0, 1'b0, 12'h0BB, 32'h0, 32'h0000BBBB, 1'b0);
    wait_done();

    // req1 withdrawn one cycle before the IDLE slot
    s_waits = 4; s_rdata = 32'h0000CCCC;
    do_req(0, 1'b0, 12'h0CC, 32'h0, 32'h0000CCCC, 1'b0);
    req_write[1] = 1'b1; req_addr[23:12] = 12'h0DD; req_wdata[63:32] = 32'hDDDDDDDD;
    req_valid[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (psel && penable && pready) break;
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    wait_done();
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (psel || req_ready != 2'b00) seen = 1;
      @(negedge clk);
    end
    chk("t6_no_transfer_req1", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
